// File: rtl/imem_arbiter_if.sv
// Bus bundle for imem_arbiter: Wishbone slave port, RVmyth fetch port and SRAM port.
// slave = arbiter view, master = environment view.
interface imem_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic              wbs_stb_i;
  logic              wbs_cyc_i;
  logic              wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [31:0]       wbs_dat_i;
  logic [31:0]       wbs_adr_i;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;

  logic              core_req_i;
  logic [ADDR_W-1:0] core_addr_i;
  logic              core_gnt_o;
  logic              core_rvalid_o;
  logic [31:0]       core_rdata_o;
  logic              core_hold_o;

  logic              mem_en_o;
  logic [3:0]        mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o,
    input  core_req_i, core_addr_i,
    output core_gnt_o, core_rvalid_o, core_rdata_o, core_hold_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o,
    output core_req_i, core_addr_i,
    input  core_gnt_o, core_rvalid_o, core_rdata_o, core_hold_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one single-port instruction SRAM between Wishbone and the RVmyth fetch port.
// Define IMEM_ARB_STATS_EN to add the 16-bit contention counter behind STATS (0x804).
module imem_arbiter #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  imem_arbiter_if.slave bus,
  output logic          dbg_state
);

  // Handshakes: a fetch is accepted in the cycle core_gnt_o=1 and its data is valid
  // (core_rvalid_o) exactly one cycle later; a Wishbone master holds stb&cyc until wbs_ack_o.
  typedef enum logic {IDLE = 1'b0, WB_ACK = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        hold, last_core, rvalid_q, ack_mem_rd;
  logic [31:0] ctrl_rdata_q, ctrl_rdata;
  logic [15:0] stats_rd;
  logic        wb_hit, wb_mem, wb_wr, core_elig, contend, wb_go, core_go;
  logic        ctrl_sel, stats_sel, ctrl_wr;
  logic        unused_adr_bits;

  assign wb_hit    = bus.wbs_stb_i & bus.wbs_cyc_i &
                     (bus.wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  assign wb_mem    = ~bus.wbs_adr_i[11];
  assign wb_wr     = bus.wbs_we_i;
  assign core_elig = bus.core_req_i & ~hold;
  assign contend   = wb_rst_ni & (state == IDLE) & wb_hit & core_elig;
  assign ctrl_sel  = (bus.wbs_adr_i[11:2] == 10'h200);
  assign stats_sel = (bus.wbs_adr_i[11:2] == 10'h201);
  assign ctrl_wr   = wb_go & ~wb_mem & wb_wr & ctrl_sel & bus.wbs_sel_i[0];
  assign unused_adr_bits = ^bus.wbs_adr_i[1:0];

  // On contention the requester that did not win last time gets the SRAM.
  always_comb begin
    wb_go   = 1'b0;
    core_go = 1'b0;
    if (wb_rst_ni && state == IDLE) begin
      if (wb_hit && core_elig) begin
        wb_go   = last_core;
        core_go = ~last_core;
      end else begin
        wb_go   = wb_hit;
        core_go = core_elig;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wb_go) state_nxt = WB_ACK;
      WB_ACK:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_en_o    = 1'b0;
    bus.mem_we_o    = 4'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    bus.core_gnt_o  = core_go;
    bus.wbs_ack_o   = (state == WB_ACK);
    bus.wbs_dat_o   = '0;
    if (core_go) begin
      bus.mem_en_o   = 1'b1;
      bus.mem_addr_o = bus.core_addr_i;
    end else if (wb_go && wb_mem) begin
      bus.mem_en_o    = 1'b1;
      bus.mem_we_o    = wb_wr ? bus.wbs_sel_i : 4'b0;
      bus.mem_addr_o  = bus.wbs_adr_i[ADDR_W+1:2];
      bus.mem_wdata_o = wb_wr ? bus.wbs_dat_i : 32'h0;
    end
    if (state == WB_ACK) bus.wbs_dat_o = ack_mem_rd ? bus.mem_rdata_i : ctrl_rdata_q;
  end

  always_comb begin
    ctrl_rdata = '0;
    if (ctrl_sel)       ctrl_rdata = {31'b0, hold};
    else if (stats_sel) ctrl_rdata = {16'b0, stats_rd};
  end

  // Register reads are captured on the issue cycle and returned during WB_ACK.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      hold         <= 1'b1;
      last_core    <= 1'b1;
      rvalid_q     <= 1'b0;
      ack_mem_rd   <= 1'b0;
      ctrl_rdata_q <= '0;
    end else begin
      rvalid_q     <= core_go;
      ack_mem_rd   <= wb_go & wb_mem & ~wb_wr;
      ctrl_rdata_q <= (wb_go & ~wb_mem & ~wb_wr) ? ctrl_rdata : 32'h0;
      if (ctrl_wr) hold <= bus.wbs_dat_i[0];
      if (wb_go)        last_core <= 1'b0;
      else if (core_go) last_core <= 1'b1;
    end
  end

`ifdef IMEM_ARB_STATS_EN
  logic [15:0] stats_q;
  logic        stats_wr;
  assign stats_wr = wb_go & ~wb_mem & wb_wr & stats_sel;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)                        stats_q <= '0;
    else if (stats_wr)                     stats_q <= '0;
    else if (contend && stats_q != 16'hFFFF) stats_q <= stats_q + 16'd1;
  end
  assign stats_rd = stats_q;
`else
  logic unused_contend;
  assign unused_contend = contend;
  assign stats_rd = '0;
`endif

  assign bus.core_rvalid_o = rvalid_q;
  assign bus.core_rdata_o  = rvalid_q ? bus.mem_rdata_i : 32'h0;
  assign bus.core_hold_o   = hold;
  assign dbg_state         = state;

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter ADDR_W SHALL default to 8 and set the memory word-address width (256 x 32-bit words).
REQ-003 Parameter BASE_ADDR SHALL default to 32'h3000_0000 and set the Wishbone decode base, with wbs_adr_i[31:12] compared.
REQ-004 Port wb_clk_i, input, 1 bit, SHALL be the single clock.
REQ-005 Port wb_rst_ni, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-006 Ports wbs_stb_i, wbs_cyc_i and wbs_we_i (input, 1 bit each) SHALL carry Wishbone classic strobe, cycle and write.
REQ-007 Ports wbs_sel_i (input, 4 bits), wbs_dat_i (input, 32 bits) and wbs_adr_i (input, 32 bits) SHALL carry Wishbone byte select, write data and address.
REQ-008 Ports wbs_ack_o (output, 1 bit) and wbs_dat_o (output, 32 bits) SHALL carry Wishbone acknowledge and read data.
REQ-009 Ports core_req_i (input, 1 bit) and core_addr_i (input, ADDR_W bits) SHALL carry the RVmyth fetch request and word address.
REQ-010 Ports core_gnt_o (output, 1 bit), core_rvalid_o (output, 1 bit) and core_rdata_o (output, 32 bits) SHALL carry the fetch grant, read-data valid and fetched word.
REQ-011 Port core_hold_o, output, 1 bit, SHALL hold the core in reset while high.
REQ-012 Ports mem_en_o (1 bit), mem_we_o (4 bits), mem_addr_o (ADDR_W bits) and mem_wdata_o (32 bits), all outputs, SHALL drive the single-port SRAM.
REQ-013 Port mem_rdata_i, input, 32 bits, SHALL carry SRAM read data with 1-cycle latency.

Function
REQ-014 A Wishbone hit SHALL be wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:12]==BASE_ADDR[31:12]); non-hits are never acked and leave all outputs idle.
REQ-015 A hit with wbs_adr_i[11]=0 SHALL target memory word wbs_adr_i[ADDR_W+1:2]; higher offset bits alias.
REQ-016 A hit with wbs_adr_i[11]=1 SHALL target control registers: offset 0x800 is CTRL (bit0 HOLD, RW; bits[31:1] read 0); offset 0x804 is STATS (see REQ-030).
REQ-017 FSM states SHALL be IDLE, WB_ACK and CORE_ONLY-free pipelining, with core fetches issued from IDLE.
REQ-018 In IDLE, the block SHALL issue exactly one SRAM access per cycle, or none.
REQ-019 A core fetch SHALL be eligible only when core_req_i=1 and HOLD=0.
REQ-020 When a core fetch is issued: core_gnt_o=1 and mem_en_o=1 with mem_we_o=0 in the same cycle; next cycle core_rvalid_o=1 and core_rdata_o=mem_rdata_i.
REQ-021 Back-to-back core fetches SHALL sustain one per cycle when no Wishbone hit is pending.
REQ-022 A Wishbone memory access SHALL be issued in IDLE: mem_en_o=1, mem_we_o=wbs_we_i ? wbs_sel_i : 4'b0; the FSM then enters WB_ACK.
REQ-023 In WB_ACK, the block SHALL set wbs_ack_o=1 for exactly one cycle, with wbs_dat_o=mem_rdata_i on reads; no SRAM access is issued; the FSM returns to IDLE.
REQ-024 Control-register accesses SHALL follow the same IDLE->WB_ACK timing without SRAM access; a write updates the register on the issue cycle.
REQ-025 When a core fetch and a Wishbone hit are both eligible in IDLE, the requester not granted last SHALL win (round-robin), so Wishbone waits at most one core fetch.
REQ-026 wbs_dat_o SHALL be 0 whenever wbs_ack_o=0.
REQ-027 core_hold_o SHALL equal HOLD; HOLD 1->0 takes effect on the cycle after the write issue cycle.

Reset
REQ-028 While wb_rst_ni=0, the block SHALL hold: FSM=IDLE, HOLD=1, round-robin last-grant=core, and all outputs 0 except core_hold_o=1.
REQ-029 Reset asserted mid-access SHALL abort the access with no ack or rvalid issued afterwards.

Configuration
REQ-030 With IMEM_ARB_STATS_EN defined, STATS SHALL be a 16-bit saturating counter of cycles in which both requesters were eligible in IDLE, cleared by reset or any write to 0x804; without the macro, STATS SHALL read 0, writes SHALL be ignored, and no counter logic shall exist.

Verification
REQ-031 Reset release -> core_hold_o=1, and core_req_i=1 yields no core_gnt_o.
REQ-032 WB write 0x3000_0010 = 32'hDEAD_BEEF with sel 4'hF -> mem_we_o=4'hF at mem_addr_o=4 and ack one cycle later; WB read of the same address -> wbs_dat_o=32'hDEAD_BEEF.
REQ-033 WB write 0x3000_0800 = 0, then core_req_i=1 held with addresses 0..3 -> core_gnt_o=1 for 4 consecutive cycles and rvalid 1 cycle after each grant.
REQ-034 Continuous core_req_i plus a WB read hit -> WB access issued within 2 cycles, core stalled for exactly 2 cycles.
REQ-035 WB read of 0x3000_1000 (non-hit) -> no ack and mem_en_o=0.
REQ-036 With IMEM_ARB_STATS_EN defined, 3 contention cycles -> read of 0x804 returns 3; write to 0x804 -> a subsequent read returns 0.
